// File: rtl/cpu_run_sequencer_if.sv
// Run-control bundle between the sequencer (slave) and the bring-up harness (master).
// CPU_RUN_SEQ_HALT_STAMP_EN adds the per-core halt_stamp bus.
interface cpu_run_sequencer_if #(
  parameter int NUM_CORES = 1,
  parameter int CNT_W     = 32
);
  logic                 start;
  logic                 abort;
  logic [NUM_CORES-1:0] halt;
  logic [NUM_CORES-1:0] core_reset;
  logic                 busy;
  logic                 trace_en;
  logic                 done;
  logic                 timeout;
  logic [CNT_W-1:0]     cycle_count;
`ifdef CPU_RUN_SEQ_HALT_STAMP_EN
  logic [NUM_CORES*CNT_W-1:0] halt_stamp;

  modport master (
    output start, abort, halt,
    input  core_reset, busy, trace_en, done, timeout, cycle_count, halt_stamp
  );
  modport slave (
    input  start, abort, halt,
    output core_reset, busy, trace_en, done, timeout, cycle_count, halt_stamp
  );
`else
  modport master (
    output start, abort, halt,
    input  core_reset, busy, trace_en, done, timeout, cycle_count
  );
  modport slave (
    input  start, abort, halt,
    output core_reset, busy, trace_en, done, timeout, cycle_count
  );
`endif
endinterface

// File: rtl/cpu_run_sequencer.sv
// Sequences cores through reset hold, bounded run and drain, then reports done/timeout.
// Optional per-core halt timestamps are enabled with CPU_RUN_SEQ_HALT_STAMP_EN.
module cpu_run_sequencer #(
  parameter int NUM_CORES        = 1,
  parameter int RESET_CYCLES     = 2,
  parameter int RUN_CYCLES       = 1000,
  parameter int DRAIN_CYCLES     = 7,
  parameter int CNT_W            = 32,
  parameter int REQUIRE_ALL_HALT = 1
) (
  input logic                  clk,
  input logic                  reset,
  cpu_run_sequencer_if.slave   bus
);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_RESET_HOLD = 3'd1,
    ST_RUN        = 3'd2,
    ST_DRAIN      = 3'd3,
    ST_DONE       = 3'd4
  } state_t;

  localparam int PH_MAX = (RESET_CYCLES > DRAIN_CYCLES) ? RESET_CYCLES : DRAIN_CYCLES;
  localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

  localparam logic [PH_W-1:0]  PH_ZERO    = {PH_W{1'b0}};
  localparam logic [PH_W-1:0]  PH_ONE     = PH_W'(1);
  localparam logic [PH_W-1:0]  RESET_LAST = PH_W'(RESET_CYCLES - 1);
  localparam logic [PH_W-1:0]  DRAIN_LAST = PH_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] RUN_LIMIT  = CNT_W'(RUN_CYCLES);
  // With no drain window the run exits straight to DONE.
  localparam state_t           RUN_EXIT   = (DRAIN_CYCLES == 0) ? ST_DONE : ST_DRAIN;

  state_t               state_q, state_d;
  logic [PH_W-1:0]      phase_q, phase_d;
  logic [CNT_W-1:0]     cycle_count_q, cycle_count_d;
  logic [NUM_CORES-1:0] halt_seen_q, halt_seen_d;
  logic                 timeout_q, timeout_d;
`ifdef CPU_RUN_SEQ_HALT_STAMP_EN
  logic [NUM_CORES*CNT_W-1:0] halt_stamp_q, halt_stamp_d;
`endif

  logic [CNT_W-1:0]     cycle_inc_s;
  logic [NUM_CORES-1:0] halt_merged_s;
  logic                 halt_cond_s;

  // Saturating run counter increment and halt-condition evaluation.
  always_comb begin
    cycle_inc_s   = (cycle_count_q == CNT_MAX) ? cycle_count_q : cycle_count_q + CNT_ONE;
    halt_merged_s = halt_seen_q | bus.halt;
    if (REQUIRE_ALL_HALT != 0) begin
      halt_cond_s = &halt_merged_s;
    end else begin
      halt_cond_s = |halt_merged_s;
    end
  end

  // Next-state and next-register computation; abort overrides every transition.
  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    cycle_count_d = cycle_count_q;
    halt_seen_d   = halt_seen_q;
    timeout_d     = timeout_q;
`ifdef CPU_RUN_SEQ_HALT_STAMP_EN
    halt_stamp_d  = halt_stamp_q;
`endif
    if (bus.abort) begin
      state_d   = ST_IDLE;
      timeout_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            state_d       = ST_RESET_HOLD;
            phase_d       = PH_ZERO;
            cycle_count_d = CNT_ZERO;
            halt_seen_d   = {NUM_CORES{1'b0}};
            timeout_d     = 1'b0;
`ifdef CPU_RUN_SEQ_HALT_STAMP_EN
            halt_stamp_d  = {(NUM_CORES*CNT_W){1'b0}};
`endif
          end else begin
            state_d = state_q;
          end
        end
        ST_RESET_HOLD: begin
          if (phase_q == RESET_LAST) begin
            state_d = ST_RUN;
            phase_d = PH_ZERO;
          end else begin
            phase_d = phase_q + PH_ONE;
          end
        end
        ST_RUN: begin
          cycle_count_d = cycle_inc_s;
          halt_seen_d   = halt_merged_s;
`ifdef CPU_RUN_SEQ_HALT_STAMP_EN
          for (int i = 0; i < NUM_CORES; i++) begin
            if (bus.halt[i] && !halt_seen_q[i]) begin
              halt_stamp_d[i*CNT_W +: CNT_W] = cycle_inc_s;
            end else begin
              halt_stamp_d[i*CNT_W +: CNT_W] = halt_stamp_q[i*CNT_W +: CNT_W];
            end
          end
`endif
          // A halt landing on the last budget cycle is not a timeout.
          if (halt_cond_s) begin
            state_d   = RUN_EXIT;
            phase_d   = PH_ZERO;
            timeout_d = 1'b0;
          end else if (cycle_inc_s == RUN_LIMIT) begin
            state_d   = RUN_EXIT;
            phase_d   = PH_ZERO;
            timeout_d = 1'b1;
          end else begin
            state_d = state_q;
          end
        end
        ST_DRAIN: begin
          if (phase_q == DRAIN_LAST) begin
            state_d = ST_DONE;
            phase_d = PH_ZERO;
          end else begin
            phase_d = phase_q + PH_ONE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      phase_q       <= PH_ZERO;
      cycle_count_q <= CNT_ZERO;
      halt_seen_q   <= {NUM_CORES{1'b0}};
      timeout_q     <= 1'b0;
`ifdef CPU_RUN_SEQ_HALT_STAMP_EN
      halt_stamp_q  <= {(NUM_CORES*CNT_W){1'b0}};
`endif
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      cycle_count_q <= cycle_count_d;
      halt_seen_q   <= halt_seen_d;
      timeout_q     <= timeout_d;
`ifdef CPU_RUN_SEQ_HALT_STAMP_EN
      halt_stamp_q  <= halt_stamp_d;
`endif
    end
  end

  logic core_rst_s;

  // Output decode straight from the state register, so async reset reaches core_reset at once.
  always_comb begin
    core_rst_s = (state_q == ST_IDLE) || (state_q == ST_RESET_HOLD) || (state_q == ST_DONE);
  end

  assign bus.core_reset  = {NUM_CORES{core_rst_s}};
  assign bus.busy        = (state_q == ST_RESET_HOLD) || (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign bus.trace_en    = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign bus.done        = (state_q == ST_DONE);
  assign bus.timeout     = timeout_q;
  assign bus.cycle_count = cycle_count_q;
`ifdef CPU_RUN_SEQ_HALT_STAMP_EN
  assign bus.halt_stamp  = halt_stamp_q;
`endif

endmodule

// File: tb/tb_cpu_run_sequencer.sv
// Directed bench for cpu_run_sequencer: three parameterisations driven from a vector table
// plus hand-written abort and async-reset sequences. Honours CPU_RUN_SEQ_HALT_STAMP_EN.
module tb_cpu_run_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic       start_v [3];
  logic       abort_v;
  logic [1:0] halt_v  [3];

  logic        o_busy [3];
  logic        o_trace[3];
  logic        o_done [3];
  logic        o_to   [3];
  logic [1:0]  o_cr   [3];
  logic [31:0] o_cc   [3];
  logic [31:0] o_st   [3][2];

  localparam int RC[3] = '{2, 3, 1};

  cpu_run_sequencer_if #(.NUM_CORES(1), .CNT_W(32)) if0 ();
  cpu_run_sequencer_if #(.NUM_CORES(2), .CNT_W(32)) if1 ();
  cpu_run_sequencer_if #(.NUM_CORES(2), .CNT_W(32)) if2 ();

  cpu_run_sequencer u0 (.clk(clk), .reset(reset), .bus(if0));
  cpu_run_sequencer #(.NUM_CORES(2), .RESET_CYCLES(3), .RUN_CYCLES(100), .DRAIN_CYCLES(3),
                      .REQUIRE_ALL_HALT(1)) u1 (.clk(clk), .reset(reset), .bus(if1));
  cpu_run_sequencer #(.NUM_CORES(2), .RESET_CYCLES(1), .RUN_CYCLES(20), .DRAIN_CYCLES(0),
                      .REQUIRE_ALL_HALT(0)) u2 (.clk(clk), .reset(reset), .bus(if2));

  assign if0.start = start_v[0];
  assign if1.start = start_v[1];
  assign if2.start = start_v[2];
  assign if0.abort = abort_v;
  assign if1.abort = abort_v;
  assign if2.abort = abort_v;
  assign if0.halt  = halt_v[0][0:0];
  assign if1.halt  = halt_v[1];
  assign if2.halt  = halt_v[2];

  assign o_busy[0] = if0.busy;     assign o_busy[1] = if1.busy;     assign o_busy[2] = if2.busy;
  assign o_trace[0] = if0.trace_en; assign o_trace[1] = if1.trace_en; assign o_trace[2] = if2.trace_en;
  assign o_done[0] = if0.done;     assign o_done[1] = if1.done;     assign o_done[2] = if2.done;
  assign o_to[0]   = if0.timeout;  assign o_to[1]   = if1.timeout;  assign o_to[2]   = if2.timeout;
  assign o_cr[0]   = {if0.core_reset, if0.core_reset};
  assign o_cr[1]   = if1.core_reset;
  assign o_cr[2]   = if2.core_reset;
  assign o_cc[0]   = if0.cycle_count;
  assign o_cc[1]   = if1.cycle_count;
  assign o_cc[2]   = if2.cycle_count;
`ifdef CPU_RUN_SEQ_HALT_STAMP_EN
  assign o_st[0][0] = if0.halt_stamp;
  assign o_st[0][1] = 32'd0;
  assign o_st[1][0] = if1.halt_stamp[31:0];
  assign o_st[1][1] = if1.halt_stamp[63:32];
  assign o_st[2][0] = if2.halt_stamp[31:0];
  assign o_st[2][1] = if2.halt_stamp[63:32];
`else
  assign o_st[0][0] = 32'd0; assign o_st[0][1] = 32'd0;
  assign o_st[1][0] = 32'd0; assign o_st[1][1] = 32'd0;
  assign o_st[2][0] = 32'd0; assign o_st[2][1] = 32'd0;
`endif

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // h0/h1: RUN cycle (1-based) at which halt[i] rises and stays high; 0 = never.
  typedef struct {
    int dut;
    int h0;
    int h1;
    bit spam;
    int exp_cc;
    bit exp_to;
    int exp_trace;
    int exp_st0;
    int exp_st1;
  } vec_t;

  vec_t vecs[9];

  task automatic run_vec(input int idx);
    vec_t v;
    int d, r, n, hold, tr;
    bit finished;
    v = vecs[idx];
    d = v.dut;
    r = RC[d];
    hold = 0;
    tr = 0;
    finished = 1'b0;
    @(negedge clk);
    start_v[d] = 1'b1;
    @(posedge clk);
    #1;
    start_v[d] = 1'b0;
    for (n = 0; n < 1500; n++) begin
      if (n == 0) begin
        chk($sformatf("v%0d_hold_busy", idx), o_busy[d], 1);
        chk($sformatf("v%0d_hold_corerst", idx), o_cr[d], 3);
        chk($sformatf("v%0d_hold_done", idx), o_done[d], 0);
        chk($sformatf("v%0d_hold_cc", idx), o_cc[d], 0);
        chk($sformatf("v%0d_hold_trace", idx), o_trace[d], 0);
      end
      if (o_busy[d] && o_cr[d][0]) hold++;
      if (o_trace[d]) tr++;
      if (o_done[d]) begin
        finished = 1'b1;
        break;
      end
      if (v.h0 != 0 && n == r + v.h0 - 1) halt_v[d][0] = 1'b1;
      if (v.h1 != 0 && n == r + v.h1 - 1) halt_v[d][1] = 1'b1;
      start_v[d] = v.spam && (n % 7 == 3);
      @(posedge clk);
      #1;
    end
    start_v[d] = 1'b0;
    chk($sformatf("v%0d_finished", idx), finished, 1);
    chk($sformatf("v%0d_hold_cycles", idx), hold, r);
    chk($sformatf("v%0d_trace_cycles", idx), tr, v.exp_trace);
    chk($sformatf("v%0d_cycle_count", idx), o_cc[d], v.exp_cc);
    chk($sformatf("v%0d_timeout", idx), o_to[d], v.exp_to);
    chk($sformatf("v%0d_done_busy", idx), o_busy[d], 0);
    chk($sformatf("v%0d_done_corerst", idx), o_cr[d], 3);
`ifdef CPU_RUN_SEQ_HALT_STAMP_EN
    chk($sformatf("v%0d_stamp0", idx), o_st[d][0], v.exp_st0);
    chk($sformatf("v%0d_stamp1", idx), o_st[d][1], v.exp_st1);
`endif
    halt_v[d] = 2'b00;
    @(posedge clk);
    #1;
    chk($sformatf("v%0d_done_held", idx), o_done[d], 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //               dut h0   h1  spam cc  to trace st0 st1
    vecs[0] = '{0,   0,   0, 1'b0, 1000, 1'b1, 1007,   0,   0};
    vecs[1] = '{1,  10,  40, 1'b0,   40, 1'b0,   43,  10,  40};
    vecs[2] = '{1,   5,   0, 1'b0,  100, 1'b1,  103,   5,   0};
    vecs[3] = '{1,   1,   1, 1'b0,    1, 1'b0,    4,   1,   1};
    vecs[4] = '{1, 100, 100, 1'b0,  100, 1'b0,  103, 100, 100};
    vecs[5] = '{2,   0,   5, 1'b0,    5, 1'b0,    5,   0,   5};
    vecs[6] = '{2,  20,   0, 1'b0,   20, 1'b0,   20,  20,   0};
    vecs[7] = '{2,   0,   0, 1'b1,   20, 1'b1,   20,   0,   0};
    vecs[8] = '{0,   3,   0, 1'b1,    3, 1'b0,   10,   3,   0};

    for (int i = 0; i < 3; i++) begin
      start_v[i] = 1'b0;
      halt_v[i]  = 2'b00;
    end
    abort_v = 1'b0;

    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst%0d_corerst", i), o_cr[i], 3);
      chk($sformatf("rst%0d_busy", i), o_busy[i], 0);
      chk($sformatf("rst%0d_done", i), o_done[i] | o_trace[i] | o_to[i], 0);
      chk($sformatf("rst%0d_cc", i), o_cc[i], 0);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_idle_busy", o_busy[0], 0);
    chk("post_rst_idle_corerst", o_cr[0], 3);

    // Abort during RUN cycle 50 of the default instance.
    @(negedge clk);
    start_v[0] = 1'b1;
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    for (int n = 0; n < RC[0] + 50 - 1; n++) begin
      @(posedge clk);
      #1;
    end
    chk("abort_pre_cc", o_cc[0], 49);
    chk("abort_pre_trace", o_trace[0], 1);
    abort_v = 1'b1;
    @(posedge clk);
    #1;
    abort_v = 1'b0;
    chk("abort_busy", o_busy[0], 0);
    chk("abort_corerst", o_cr[0], 3);
    chk("abort_done", o_done[0], 0);
    chk("abort_timeout", o_to[0], 0);
    chk("abort_cc_held", o_cc[0], 49);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_stays_idle", o_busy[0], 0);

    for (int i = 0; i < 9; i++) run_vec(i);

    // Async reset while draining.
    @(negedge clk);
    start_v[1] = 1'b1;
    @(posedge clk);
    #1;
    start_v[1] = 1'b0;
    for (int n = 0; n < RC[1] + 2; n++) begin
      if (n == RC[1] + 1) halt_v[1] = 2'b11;
      @(posedge clk);
      #1;
    end
    chk("drain_entered_trace", o_trace[1], 1);
    chk("drain_entered_corerst", o_cr[1], 0);
    chk("drain_entered_cc", o_cc[1], 2);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_corerst", o_cr[1], 3);
    chk("arst_trace", o_trace[1], 0);
    chk("arst_done", o_done[1], 0);
    chk("arst_busy", o_busy[1], 0);
    halt_v[1] = 2'b00;
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("arst_no_done", o_done[1], 0);
    chk("arst_idle_corerst", o_cr[1], 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
